hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
Forwarding and hazard controller for the 4-stage in-order integer pipeline. It keeps a shadow pipeline of in-flight destination registers for the EX, MEM and WB stages. Each cycle it compares the issuing instruction's source registers against that shadow pipeline and produces two registered 4-bit forwarding selects, one per operand MUX_DataDependency instance. It also raises a combinational load-use stall.

Parameters:
REG_ADDR_W, 5, register index width
STALL_CNT_W, 16, width of optional stall counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  instruction in decode/issue is valid
issue_rs1  in  REG_ADDR_W  source register A
issue_rs2  in  REG_ADDR_W  source register B
issue_use_rs1  in  1  instruction reads rs1
issue_use_rs2  in  1  instruction reads rs2
issue_rd  in  REG_ADDR_W  destination register
issue_wr_en  in  1  instruction writes rd
issue_is_load  in  1  instruction is a load
flush  in  1  kill issuing and EX instructions (branch taken)
stall  out  1  hold fetch/issue, inject bubble (combinational)
fwd_ctrl_a  out  4  MuxCtrl for operand A mux, valid while instruction is in EX
fwd_ctrl_b  out  4  MuxCtrl for operand B mux, valid while instruction is in EX
stall_count  out  STALL_CNT_W  only with HAZ_STALL_CNT_EN

Behaviour:
- Shadow slots EX, MEM and WB each hold {valid, rd, wr_en, is_load}. Reset: all slots invalid, fwd_ctrl_a = fwd_ctrl_b = 4'b0000; stall is therefore 0.
- Producer P counts only if P.valid & P.wr_en & P.rd != 0. Register 0 is never forwarded and never stalls.
- Operand A matches P when issue_use_rs1 & issue_rs1 == P.rd. Operand B uses rs2/use_rs2 the same way.
- stall = issue_valid & !flush & EX slot is a counting load & (match A | match B).
- Every rising edge, unconditionally: MEM -> WB, EX -> MEM.
- EX slot load rule: if issue_valid & !stall & !flush, EX <- issue fields and fwd_ctrl_a/b <- computed codes. Otherwise EX <- invalid and fwd_ctrl_a/b <- 4'b0000 (bubble).
- Code priority per operand, nearest producer first (the first matching slot wins):
  1. EX slot, non-load: A 4'b0001, B 4'b0010 (fast EX result). An EX-slot load cannot reach here; it stalls.
  2. MEM slot, non-load: A 4'b0011, B 4'b0100.
  3. MEM slot, load: A 4'b0101, B 4'b0110.
  4. WB slot, load: A 4'b0111, B 4'b1000.
  5. WB slot, non-load, or no match: 4'b0000. The register file is write-first and covers it.
- Both operands matching the same producer get their respective A and B codes in the same cycle.
- Load-use takes exactly 1 stall cycle. Next cycle the load sits in MEM, stall drops, and the consumer issues with 0101/0110.
- flush has priority over stall and issue: the EX slot is cleared, and MEM/WB advance normally.
- Async reset mid-operation clears all slots and outputs immediately.
- Target: the fwd_ctrl outputs feed MuxCtrl directly. No other code value may appear.

Optional Feature:
HAZ_STALL_CNT_EN: when defined, port stall_count exists.
- Increments on every clock edge where stall = 1.
- Saturates at all-ones.
- Reset to 0 by rst_n.
When undefined, the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then issue add r3 <- r1,r2, then sub r4 <- r3,r5 back-to-back -> second instruction in EX: fwd_ctrl_a = 0001, fwd_ctrl_b = 0000, stall never 1.
- lw r6, then add r7 <- r8,r6 next cycle -> stall = 1 for exactly one cycle, bubble fwd = 0000/0000, then fwd_ctrl_b = 0110.
- lw r6, nop, add r7 <- r6,r6 -> no stall, fwd_ctrl_a = 0101, fwd_ctrl_b = 0110.
- Writes to r0 by add then lw, consumers read r0 -> no stall, all codes 0000. Separately, add r2 then add r2 then use r2 -> nearest wins, A = 0001.
- lw r9 followed by dependent use with flush = 1 in the same cycle -> stall = 0, EX bubble, codes 0000. Also assert rst_n low mid-stream -> outputs 0000 asynchronously.
- With HAZ_STALL_CNT_EN and STALL_CNT_W = 2: five load-use pairs -> stall_count 1, 2, 3, 3, 3 (saturates).

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: forwarding and load-use hazard controller for the 4-stage
// in-order integer pipeline. It keeps a shadow pipeline of destination registers
// for the EX, MEM and WB stages and compares the issuing instruction's source
// registers against it.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   issue_*                 decode/issue instruction fields
//   flush                   kills the issuing instruction (EX slot loads a bubble)
//   stall                   combinational load-use stall (hold fetch/issue)
//   fwd_ctrl_a/_b           registered operand-mux selects, valid while the
//                           instruction is in EX
//   stall_count             saturating stall counter (HAZ_STALL_CNT_EN only)
//
// Optional feature macro: HAZ_STALL_CNT_EN adds the stall_count port and counter.
module hazard_fwd_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  issue_use_rs1,
  input  logic                  issue_use_rs2,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_wr_en,
  input  logic                  issue_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [3:0]            fwd_ctrl_a,
  output logic [3:0]            fwd_ctrl_b
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  localparam logic [3:0] CODE_NONE    = 4'b0000;
  localparam logic [3:0] A_EX_ALU     = 4'b0001;
  localparam logic [3:0] B_EX_ALU     = 4'b0010;
  localparam logic [3:0] A_MEM_ALU    = 4'b0011;
  localparam logic [3:0] B_MEM_ALU    = 4'b0100;
  localparam logic [3:0] A_MEM_LD     = 4'b0101;
  localparam logic [3:0] B_MEM_LD     = 4'b0110;
  localparam logic [3:0] A_WB_LD      = 4'b0111;
  localparam logic [3:0] B_WB_LD      = 4'b1000;

  // Shadow pipeline slots
  logic                  ex_v_q,  mem_v_q,  wb_v_q;
  logic                  ex_w_q,  mem_w_q,  wb_w_q;
  logic                  ex_l_q,  mem_l_q,  wb_l_q;
  logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic                  ex_v_d;
  logic [3:0]            fwd_a_d, fwd_b_d;

  logic ex_prod, mem_prod, wb_prod;
  logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic issue_go;
  logic [3:0] code_a, code_b;

  // Producer qualification and per-slot operand matches
  always_comb begin
    ex_prod  = ex_v_q  & ex_w_q  & (ex_rd_q  != '0);
    mem_prod = mem_v_q & mem_w_q & (mem_rd_q != '0);
    wb_prod  = wb_v_q  & wb_w_q  & (wb_rd_q  != '0);
    a_ex  = ex_prod  & issue_use_rs1 & (issue_rs1 == ex_rd_q);
    a_mem = mem_prod & issue_use_rs1 & (issue_rs1 == mem_rd_q);
    a_wb  = wb_prod  & issue_use_rs1 & (issue_rs1 == wb_rd_q);
    b_ex  = ex_prod  & issue_use_rs2 & (issue_rs2 == ex_rd_q);
    b_mem = mem_prod & issue_use_rs2 & (issue_rs2 == mem_rd_q);
    b_wb  = wb_prod  & issue_use_rs2 & (issue_rs2 == wb_rd_q);
  end

  // Load in EX cannot forward in time: hold issue for one cycle
  always_comb begin
    stall    = issue_valid & ~flush & ex_l_q & (a_ex | b_ex);
    issue_go = issue_valid & ~stall & ~flush;
  end

  // Nearest producer wins; a WB non-load match is served by the register file
  always_comb begin
    code_a = CODE_NONE;
    if (a_ex)       code_a = A_EX_ALU;
    else if (a_mem) code_a = mem_l_q ? A_MEM_LD : A_MEM_ALU;
    else if (a_wb)  code_a = wb_l_q ? A_WB_LD : CODE_NONE;

    code_b = CODE_NONE;
    if (b_ex)       code_b = B_EX_ALU;
    else if (b_mem) code_b = mem_l_q ? B_MEM_LD : B_MEM_ALU;
    else if (b_wb)  code_b = wb_l_q ? B_WB_LD : CODE_NONE;

    ex_v_d  = issue_go;
    fwd_a_d = issue_go ? code_a : CODE_NONE;
    fwd_b_d = issue_go ? code_b : CODE_NONE;
  end

  // Shadow pipeline advance and registered selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q     <= 1'b0;
      ex_w_q     <= 1'b0;
      ex_l_q     <= 1'b0;
      ex_rd_q    <= '0;
      mem_v_q    <= 1'b0;
      mem_w_q    <= 1'b0;
      mem_l_q    <= 1'b0;
      mem_rd_q   <= '0;
      wb_v_q     <= 1'b0;
      wb_w_q     <= 1'b0;
      wb_l_q     <= 1'b0;
      wb_rd_q    <= '0;
      fwd_ctrl_a <= CODE_NONE;
      fwd_ctrl_b <= CODE_NONE;
    end else begin
      wb_v_q     <= mem_v_q;
      wb_w_q     <= mem_w_q;
      wb_l_q     <= mem_l_q;
      wb_rd_q    <= mem_rd_q;
      mem_v_q    <= ex_v_q;
      mem_w_q    <= ex_w_q;
      mem_l_q    <= ex_l_q;
      mem_rd_q   <= ex_rd_q;
      ex_v_q     <= ex_v_d;
      ex_w_q     <= ex_v_d & issue_wr_en;
      ex_l_q     <= ex_v_d & issue_is_load;
      ex_rd_q    <= ex_v_d ? issue_rd : '0;
      fwd_ctrl_a <= fwd_a_d;
      fwd_ctrl_b <= fwd_b_d;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] cnt_q;

  // Saturating count of stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboarded bench for hazard_fwd_ctrl: a stage-array reference model pushes
// expected stall/select values; a negedge monitor pops and compares.
module tb_hazard_fwd_ctrl;

`ifdef HAZ_STALL_CNT_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 16;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } slot_t;

  typedef struct packed {
    logic       v;
    logic       flush;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  typedef struct packed {
    logic [3:0]       a;
    logic [3:0]       b;
    logic [CNT_W-1:0] cnt;
  } fexp_t;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       issue_use_rs1, issue_use_rs2, issue_wr_en, issue_is_load;
  logic       flush;
  logic       stall;
  logic [3:0] fwd_ctrl_a, fwd_ctrl_b;
`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count;
`endif

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .STALL_CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .issue_valid(issue_valid),
    .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1),
    .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd),
    .issue_wr_en(issue_wr_en),
    .issue_is_load(issue_is_load),
    .flush(flush),
    .stall(stall),
    .fwd_ctrl_a(fwd_ctrl_a),
    .fwd_ctrl_b(fwd_ctrl_b)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic  stall_q[$];
  fexp_t fwd_q[$];

  // Reference model: index 0 = EX, 1 = MEM, 2 = WB
  slot_t            pipe[3];
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  function automatic logic counts(input slot_t p);
    return p.v && p.wr && (p.rd != 5'd0);
  endfunction

  // Nearest matching producer decides; B code is always the A code plus one
  function automatic logic [3:0] m_code(input logic use_r, input logic [4:0] rs,
                                        input logic is_b);
    logic [3:0] a;
    for (int s = 0; s < 3; s++) begin
      if (use_r && counts(pipe[s]) && (rs == pipe[s].rd)) begin
        case (s)
          0:       a = 4'd1;
          1:       a = pipe[s].ld ? 4'd5 : 4'd3;
          default: a = pipe[s].ld ? 4'd7 : 4'd0;
        endcase
        return (a == 4'd0) ? 4'd0 : a + 4'(is_b);
      end
    end
    return 4'd0;
  endfunction

  function automatic ins_t mk(input logic v, input int rs1, input int rs2,
                              input logic u1, input logic u2, input int rd,
                              input logic wr, input logic ld, input logic fl);
    ins_t i;
    i.v = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = u1; i.u2 = u2;
    i.rd = 5'(rd); i.wr = wr; i.ld = ld; i.flush = fl;
    return i;
  endfunction

  task automatic drive(input ins_t i);
    issue_valid   = i.v;
    issue_rs1     = i.rs1;
    issue_rs2     = i.rs2;
    issue_use_rs1 = i.u1;
    issue_use_rs2 = i.u2;
    issue_rd      = i.rd;
    issue_wr_en   = i.wr;
    issue_is_load = i.ld;
    flush         = i.flush;
  endtask

  // One cycle: drive after the edge, predict stall now and selects after next edge
  task automatic step(input ins_t i, output logic st);
    logic  go;
    fexp_t f;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(i);
    st = i.v && !i.flush && counts(pipe[0]) && pipe[0].ld &&
         ((i.u1 && i.rs1 == pipe[0].rd) || (i.u2 && i.rs2 == pipe[0].rd));
    go  = i.v && !st && !i.flush;
    f.a = go ? m_code(i.u1, i.rs1, 1'b0) : 4'd0;
    f.b = go ? m_code(i.u2, i.rs2, 1'b1) : 4'd0;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = go ? slot_t'{1'b1, i.rd, i.wr, i.ld} : slot_t'(0);
    if (st && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + CNT_W'(1);
    f.cnt = m_cnt;
    stall_q.push_back(st);
    fwd_q.push_back(f);
  endtask

  // Issue an instruction, re-presenting it while the model predicts a stall
  task automatic issue(input ins_t i);
    logic st;
    for (int t = 0; t < 4; t++) begin
      step(i, st);
      if (!st) break;
    end
  endtask

  task automatic nops(input int n);
    logic st;
    for (int k = 0; k < n; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), st);
  endtask

  // Assert reset shortly after an edge; outputs must clear before the next edge
  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    m_cnt = '0;
    stall_q.delete();
    fwd_q.delete();
    stall_q.push_back(1'b0);
    fwd_q.push_back('0);
    fwd_q.push_back('0);
  endtask

  // Monitor
  always @(negedge clk) begin
    logic  es;
    fexp_t ef;
    if (stall_q.size() != 0) begin
      es = stall_q.pop_front();
      chk("stall", int'(stall), int'(es));
    end
    if (fwd_q.size() != 0) begin
      ef = fwd_q.pop_front();
      chk("fwd_ctrl_a", int'(fwd_ctrl_a), int'(ef.a));
      chk("fwd_ctrl_b", int'(fwd_ctrl_b), int'(ef.b));
`ifdef HAZ_STALL_CNT_EN
      chk("stall_count", int'(stall_count), int'(ef.cnt));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st;
    ins_t r;
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    m_cnt = '0;

    reset_cycle();
    // add r3 <- r1,r2 ; sub r4 <- r3,r5
    issue(mk(1, 1, 2, 1, 1, 3, 1, 0, 0));
    issue(mk(1, 3, 5, 1, 1, 4, 1, 0, 0));
    nops(3);
    // lw r6 ; add r7 <- r8,r6 (load-use)
    issue(mk(1, 0, 0, 1, 0, 6, 1, 1, 0));
    issue(mk(1, 8, 6, 1, 1, 7, 1, 0, 0));
    nops(3);
    // lw r6 ; nop ; add r7 <- r6,r6
    issue(mk(1, 0, 0, 1, 0, 6, 1, 1, 0));
    nops(1);
    issue(mk(1, 6, 6, 1, 1, 7, 1, 0, 0));
    nops(3);
    // writes to r0 never forward or stall
    issue(mk(1, 1, 2, 1, 1, 0, 1, 0, 0));
    issue(mk(1, 0, 0, 1, 0, 0, 1, 1, 0));
    issue(mk(1, 0, 0, 1, 1, 9, 1, 0, 0));
    nops(3);
    // add r2 ; add r2 ; use r2 -> nearest wins
    issue(mk(1, 1, 1, 1, 1, 2, 1, 0, 0));
    issue(mk(1, 3, 3, 1, 1, 2, 1, 0, 0));
    issue(mk(1, 2, 0, 1, 0, 5, 1, 0, 0));
    nops(3);
    // lw r9 ; dependent use with flush
    issue(mk(1, 0, 0, 1, 0, 9, 1, 1, 0));
    issue(mk(1, 9, 9, 1, 1, 10, 1, 0, 1));
    nops(3);
    // forwarded consumer in EX, then async reset
    issue(mk(1, 0, 0, 0, 0, 1, 1, 0, 0));
    issue(mk(1, 1, 1, 1, 1, 10, 1, 0, 0));
    reset_cycle();
    // five load-use pairs
    for (int k = 0; k < 5; k++) begin
      issue(mk(1, 0, 0, 1, 0, 6, 1, 1, 0));
      issue(mk(1, 8, 6, 1, 1, 7, 1, 0, 0));
    end
    nops(3);
    // randomized traffic over a small register window to provoke hazards
    for (int k = 0; k < 500; k++) begin
      if (k == 250) reset_cycle();
      r.v     = ($urandom_range(0, 7) != 0);
      r.rs1   = 5'($urandom_range(0, 3));
      r.rs2   = 5'($urandom_range(0, 3));
      r.rd    = 5'($urandom_range(0, 3));
      r.u1    = 1'($urandom_range(0, 1));
      r.u2    = 1'($urandom_range(0, 1));
      r.wr    = ($urandom_range(0, 3) != 0);
      r.ld    = ($urandom_range(0, 2) == 0);
      r.flush = ($urandom_range(0, 9) == 0);
      if (r.v) issue(r);
      else     step(r, st);
    end

    @(posedge clk);
    #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int t = 0; t < 10; t++) begin
      if (stall_q.size() == 0 && fwd_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (stall_q.size() != 0 || fwd_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0",
               stall_q.size(), fwd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
